// File: rtl/rv_plic_pkg.sv
// -----------------------------------------------------------------------------
// rv_plic_pkg
// Shared constants and types for the PLIC gateway, target and register block.
//   PLIC_N_SOURCE / PLIC_MAX_PRIO : default source count and top priority level
//   PLIC_SRCW / PLIC_PRIOW        : derived ID and priority widths
//   src_id_t / prio_t             : ID and priority types at the default sizes
//   NO_IRQ                        : ID 0, meaning "no interrupt"
// -----------------------------------------------------------------------------
package rv_plic_pkg;

  localparam int PLIC_N_SOURCE = 32;
  localparam int PLIC_MAX_PRIO = 7;
  localparam int PLIC_SRCW     = $clog2(PLIC_N_SOURCE + 1);
  localparam int PLIC_PRIOW    = $clog2(PLIC_MAX_PRIO + 1);

  typedef logic [PLIC_SRCW-1:0]  src_id_t;
  typedef logic [PLIC_PRIOW-1:0] prio_t;

  localparam src_id_t NO_IRQ = '0;

endpackage

// File: rtl/rv_plic_target_if.sv
// -----------------------------------------------------------------------------
// rv_plic_target_if
// Register-access side of one PLIC target: claim read and complete write
// strobes in, one-hot claim/complete vectors out towards the gateway.
//   claim_re    : single-cycle strobe, read of the claim register
//   complete_we : single-cycle strobe, write of the complete register
//   complete_id : ID written together with complete_we
//   claim       : one-hot (or zero) source being claimed this cycle
//   complete    : one-hot (or zero) source being completed this cycle
//
// Strobe semantics: claim_re and complete_we are one-cycle pulses with no
// ready/backpressure. The target answers combinationally in the same cycle
// (claim, complete and the claim read data are valid only while the strobe
// is high) and the gateway acts on them at the next rising edge.
// -----------------------------------------------------------------------------
interface rv_plic_target_if
  import rv_plic_pkg::*;
#(
  parameter int N_SOURCE = PLIC_N_SOURCE,
  parameter int SRCW     = $clog2(N_SOURCE + 1)
);

  logic                claim_re;
  logic                complete_we;
  logic [SRCW-1:0]     complete_id;
  logic [N_SOURCE-1:0] claim;
  logic [N_SOURCE-1:0] complete;

  // Register block side: issues the strobes.
  modport master (
    output claim_re,
    output complete_we,
    output complete_id,
    input  claim,
    input  complete
  );

  // Target side: decodes the strobes.
  modport slave (
    input  claim_re,
    input  complete_we,
    input  complete_id,
    output claim,
    output complete
  );

endinterface

// File: rtl/rv_plic_prio_tree.sv
// -----------------------------------------------------------------------------
// rv_plic_prio_tree
// Combinational max-tree over the eligible sources. Returns the ID and
// priority of the highest-priority eligible source; the lower ID wins ties.
// Returns ID 0 / priority 0 when nothing is eligible.
//   i_eligible : per-source eligibility (bit i is source ID i+1)
//   i_prio     : per-source priority
//   o_win_id   : winning source ID, 0 if none
//   o_win_prio : priority of the winner, 0 if none
// -----------------------------------------------------------------------------
module rv_plic_prio_tree
  import rv_plic_pkg::*;
#(
  parameter int N_SOURCE = PLIC_N_SOURCE,
  parameter int SRCW     = $clog2(N_SOURCE + 1),
  parameter int PRIOW    = PLIC_PRIOW
) (
  input  logic [N_SOURCE-1:0]            i_eligible,
  input  logic [N_SOURCE-1:0][PRIOW-1:0] i_prio,
  output logic [SRCW-1:0]                o_win_id,
  output logic [PRIOW-1:0]               o_win_prio
);

  // Leaves padded to a power of two, stored as a heap: node n has children
  // 2n (left, lower IDs) and 2n+1 (right). Root is node 1.
  localparam int NP = 1 << $clog2(N_SOURCE);

  logic [2*NP-1:1]            w_vld;
  logic [2*NP-1:1][PRIOW-1:0] w_prio;
  logic [2*NP-1:1][SRCW-1:0]  w_id;

  always_comb begin
    w_vld  = '0;
    w_prio = '0;
    w_id   = '0;
    for (int l = 0; l < N_SOURCE; l++) begin
      w_vld[NP+l]  = i_eligible[l];
      w_prio[NP+l] = i_prio[l];
      w_id[NP+l]   = SRCW'(l + 1);
    end
    // Bottom-up: the right child only wins with a strictly higher priority,
    // so equal priorities resolve to the lower ID.
    for (int n = NP - 1; n >= 1; n--) begin
      if (w_vld[2*n+1] && (!w_vld[2*n] || (w_prio[2*n+1] > w_prio[2*n]))) begin
        w_vld[n]  = 1'b1;
        w_prio[n] = w_prio[2*n+1];
        w_id[n]   = w_id[2*n+1];
      end else begin
        w_vld[n]  = w_vld[2*n];
        w_prio[n] = w_prio[2*n];
        w_id[n]   = w_id[2*n];
      end
    end
  end

  assign o_win_id   = w_vld[1] ? w_id[1]   : '0;
  assign o_win_prio = w_vld[1] ? w_prio[1] : '0;

endmodule

// File: rtl/rv_plic_target.sv
// -----------------------------------------------------------------------------
// rv_plic_target
// Per-hart-context PLIC arbiter. Masks the gateway's pending vector with the
// enables and threshold, picks the highest-priority source, registers
// irq/irq_id, and turns claim reads / complete writes into one-hot vectors
// for the gateway.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ip, ie        : pending bits from the gateway, enables (bit i = ID i+1)
//   prio          : per-source priority
//   threshold     : only priorities strictly above this interrupt
//   reg_if        : claim/complete strobes in, one-hot claim/complete out
//   irq, irq_id   : registered request and winning ID (claim read data)
// -----------------------------------------------------------------------------
module rv_plic_target
  import rv_plic_pkg::*;
#(
  parameter int N_SOURCE = PLIC_N_SOURCE,
  parameter int MAX_PRIO = PLIC_MAX_PRIO,
  localparam int SRCW    = $clog2(N_SOURCE + 1),
  localparam int PRIOW   = $clog2(MAX_PRIO + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_SOURCE-1:0]            ip,
  input  logic [N_SOURCE-1:0]            ie,
  input  logic [N_SOURCE-1:0][PRIOW-1:0] prio,
  input  logic [PRIOW-1:0]               threshold,
  rv_plic_target_if.slave                reg_if,
  output logic                           irq,
  output logic [SRCW-1:0]                irq_id
);

  logic [N_SOURCE-1:0] w_eligible;
  logic [SRCW-1:0]     w_win_id;
  logic [PRIOW-1:0]    w_win_prio;
  logic                w_irq_next;
  logic                w_claim_accept;
  logic                r_irq;
  logic [SRCW-1:0]     r_irq_id;

  // Strict unsigned compare: priority 0 never fires, threshold MAX_PRIO
  // masks everything.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      w_eligible[i] = ip[i] & ie[i] & (prio[i] > threshold);
    end
  end

  rv_plic_prio_tree #(
    .N_SOURCE (N_SOURCE),
    .SRCW     (SRCW),
    .PRIOW    (PRIOW)
  ) u_prio_tree (
    .i_eligible (w_eligible),
    .i_prio     (prio),
    .o_win_id   (w_win_id),
    .o_win_prio (w_win_prio)
  );

  // An eligible winner always has priority >= 1; requiring both keeps the
  // request consistent with the ID even if the tree is reused elsewhere.
  assign w_irq_next = (w_win_id != SRCW'(NO_IRQ)) && (w_win_prio != '0);

  // A claim only counts when there is something to claim. Reading during a
  // blank cycle (irq_id == 0) therefore neither claims nor re-blanks.
  assign w_claim_accept = reg_if.claim_re && (r_irq_id != SRCW'(NO_IRQ));

  // Result register. The edge right after an accepted claim loads zero,
  // which covers the cycle in which the gateway's ip bit is still settling;
  // the next edge then picks the new winner from the updated ip.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else if (w_claim_accept) begin
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_irq    <= w_irq_next;
      r_irq_id <= w_win_id;
    end
  end

  assign irq    = r_irq;
  assign irq_id = r_irq_id;

  // One-hot decoders. ID 0 and IDs above N_SOURCE match no bit, so they
  // decode to all zeros without extra range checks.
  always_comb begin
    reg_if.claim    = '0;
    reg_if.complete = '0;
    for (int k = 0; k < N_SOURCE; k++) begin
      reg_if.claim[k]    = reg_if.claim_re && (r_irq_id == SRCW'(k + 1));
      reg_if.complete[k] = reg_if.complete_we && (reg_if.complete_id == SRCW'(k + 1));
    end
  end

endmodule

// File: tb/tb_rv_plic_target.sv
// -----------------------------------------------------------------------------
// tb_rv_plic_target
// Directed bench for rv_plic_target with a small gateway model that clears
// ip on claim and re-arms a still-asserted source after complete.
// -----------------------------------------------------------------------------
module tb_rv_plic_target;
  import rv_plic_pkg::*;

  localparam int NS = 32;
  localparam int MP = 7;
  localparam int SW = $clog2(NS + 1);
  localparam int PW = $clog2(MP + 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  rv_plic_target_if #(.N_SOURCE(NS), .SRCW(SW)) bus ();

  logic [NS-1:0]         ip;
  logic [NS-1:0]         ip_drv;
  logic [NS-1:0]         ie;
  logic [NS-1:0][PW-1:0] prio;
  logic [PW-1:0]         threshold;
  logic                  irq;
  logic [SW-1:0]         irq_id;
  logic                  use_gw;

  rv_plic_target #(.N_SOURCE(NS), .MAX_PRIO(MP)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ip        (ip),
    .ie        (ie),
    .prio      (prio),
    .threshold (threshold),
    .reg_if    (bus.slave),
    .irq       (irq),
    .irq_id    (irq_id)
  );

  // ---------------- gateway model ----------------
  logic [NS-1:0] src_lvl;
  logic [NS-1:0] gw_ip;
  logic [NS-1:0] gw_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gw_ip   <= '0;
      gw_busy <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (bus.claim[i]) begin
          gw_ip[i]   <= 1'b0;
          gw_busy[i] <= 1'b1;
        end else if (src_lvl[i] && !gw_busy[i] && !gw_ip[i]) begin
          gw_ip[i] <= 1'b1;
        end
        if (bus.complete[i]) gw_busy[i] <= 1'b0;
      end
    end
  end

  assign ip = use_gw ? gw_ip : ip_drv;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ip_drv          = '0;
    ie              = '1;
    prio            = '0;
    threshold       = '0;
    src_lvl         = '0;
    use_gw          = 1'b0;
    bus.claim_re    = 1'b0;
    bus.complete_we = 1'b0;
    bus.complete_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    ip_drv = '1;
    for (int i = 0; i < NS; i++) prio[i] = 3'd3;
    step();
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    n_checks++; if (irq_id !== 6'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", irq_id); end
    n_checks++; if (bus.claim !== 32'h0) begin n_fail++; $display("FAIL reset_claim: got %h expected 0", bus.claim); end
    n_checks++; if (bus.complete !== 32'h0) begin n_fail++; $display("FAIL reset_complete: got %h expected 0", bus.complete); end
    rst_n = 1'b1;
    step();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rel_irq: got %0b expected 1", irq); end
    n_checks++; if (irq_id !== 6'd1) begin n_fail++; $display("FAIL rel_tie_id: got %0d expected 1", irq_id); end
    // Asynchronous clear away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (irq !== 1'b0 || irq_id !== 6'd0) begin n_fail++; $display("FAIL async_reset: got irq=%0b id=%0d expected 0/0", irq, irq_id); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_arbitration();
    do_reset();
    ip_drv    = (32'h1 << 4) | (32'h1 << 9);
    prio[4]   = 3'd2;
    prio[9]   = 3'd5;
    threshold = 3'd1;
    step();
    n_checks++; if (irq !== 1'b1 || irq_id !== 6'd10) begin n_fail++; $display("FAIL arb_basic: got irq=%0b id=%0d expected 1/10", irq, irq_id); end
    threshold = 3'd5;
    step();
    n_checks++; if (irq !== 1'b0 || irq_id !== 6'd0) begin n_fail++; $display("FAIL arb_strict_thr: got irq=%0b id=%0d expected 0/0", irq, irq_id); end
    threshold = 3'd4;
    step();
    n_checks++; if (irq_id !== 6'd10) begin n_fail++; $display("FAIL arb_thr4: got %0d expected 10", irq_id); end
    prio[4] = 3'd5;
    step();
    n_checks++; if (irq_id !== 6'd5) begin n_fail++; $display("FAIL arb_tie_low_id: got %0d expected 5", irq_id); end
    ie[4] = 1'b0;
    step();
    n_checks++; if (irq_id !== 6'd10) begin n_fail++; $display("FAIL arb_ie_mask: got %0d expected 10", irq_id); end
    prio[9]   = 3'd7;
    threshold = 3'd7;
    step();
    n_checks++; if (irq !== 1'b0 || irq_id !== 6'd0) begin n_fail++; $display("FAIL arb_thr_max: got irq=%0b id=%0d expected 0/0", irq, irq_id); end
    prio[9]   = 3'd0;
    threshold = 3'd0;
    step();
    n_checks++; if (irq !== 1'b0 || irq_id !== 6'd0) begin n_fail++; $display("FAIL arb_prio0: got irq=%0b id=%0d expected 0/0", irq, irq_id); end
    ie        = '1;
    ip_drv    = 32'h8000_0000;
    prio[31]  = 3'd1;
    step();
    n_checks++; if (irq_id !== 6'd32) begin n_fail++; $display("FAIL arb_top_src: got %0d expected 32", irq_id); end
  endtask

  task automatic test_claim();
    do_reset();
    use_gw    = 1'b1;
    src_lvl   = (32'h1 << 4) | (32'h1 << 9);
    prio[4]   = 3'd2;
    prio[9]   = 3'd5;
    threshold = 3'd1;
    step();
    step();
    n_checks++; if (irq_id !== 6'd10) begin n_fail++; $display("FAIL claim_pre_id: got %0d expected 10", irq_id); end
    bus.claim_re = 1'b1;
    #1;
    n_checks++; if (bus.claim !== 32'h0000_0200) begin n_fail++; $display("FAIL claim_onehot: got %h expected 00000200", bus.claim); end
    step();
    bus.claim_re = 1'b0;
    n_checks++; if (irq !== 1'b0 || irq_id !== 6'd0) begin n_fail++; $display("FAIL claim_blank: got irq=%0b id=%0d expected 0/0", irq, irq_id); end
    step();
    n_checks++; if (irq !== 1'b1 || irq_id !== 6'd5) begin n_fail++; $display("FAIL claim_next: got irq=%0b id=%0d expected 1/5", irq, irq_id); end
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] seen;
    logic [SW-1:0] exp_id [3];
    logic [NS-1:0] exp_cl [3];
    exp_id = '{6'd10, 6'd0, 6'd5};
    exp_cl = '{32'h0000_0200, 32'h0, 32'h0000_0010};
    seen   = '0;
    do_reset();
    use_gw    = 1'b1;
    src_lvl   = (32'h1 << 4) | (32'h1 << 9);
    prio[4]   = 3'd2;
    prio[9]   = 3'd5;
    threshold = 3'd1;
    step();
    step();
    bus.claim_re = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (irq_id !== exp_id[c]) begin n_fail++; $display("FAIL b2b_read%0d: got %0d expected %0d", c, irq_id, exp_id[c]); end
      n_checks++; if (bus.claim !== exp_cl[c]) begin n_fail++; $display("FAIL b2b_claim%0d: got %h expected %h", c, bus.claim, exp_cl[c]); end
      n_checks++; if ((bus.claim & seen) !== 32'h0) begin n_fail++; $display("FAIL b2b_dup%0d: got %h expected 0", c, bus.claim & seen); end
      seen = seen | bus.claim;
      step();
    end
    bus.claim_re = 1'b0;
    n_checks++; if (irq_id !== 6'd0) begin n_fail++; $display("FAIL b2b_final_blank: got %0d expected 0", irq_id); end
  endtask

  task automatic test_complete();
    logic [SW-1:0] ids  [4];
    logic [NS-1:0] exps [4];
    ids  = '{6'd0, 6'd7, 6'd33, 6'd32};
    exps = '{32'h0, 32'h0000_0040, 32'h0, 32'h8000_0000};
    do_reset();
    ip_drv  = 32'h0000_0004;
    prio[2] = 3'd3;
    step();
    for (int v = 0; v < 4; v++) begin
      bus.complete_we = 1'b1;
      bus.complete_id = ids[v];
      #1;
      n_checks++; if (bus.complete !== exps[v]) begin n_fail++; $display("FAIL complete_id%0d: got %h expected %h", ids[v], bus.complete, exps[v]); end
      step();
      bus.complete_we = 1'b0;
      n_checks++; if (irq !== 1'b1 || irq_id !== 6'd3) begin n_fail++; $display("FAIL complete_noeffect%0d: got irq=%0b id=%0d expected 1/3", ids[v], irq, irq_id); end
    end
  endtask

  task automatic test_claim_complete_same();
    do_reset();
    use_gw  = 1'b1;
    src_lvl = 32'h0000_0004;
    prio[2] = 3'd3;
    step();
    step();
    n_checks++; if (irq_id !== 6'd3) begin n_fail++; $display("FAIL cc_pre_id: got %0d expected 3", irq_id); end
    bus.claim_re    = 1'b1;
    bus.complete_we = 1'b1;
    bus.complete_id = 6'd3;
    #1;
    n_checks++; if (bus.claim !== 32'h0000_0004) begin n_fail++; $display("FAIL cc_claim: got %h expected 00000004", bus.claim); end
    n_checks++; if (bus.complete !== 32'h0000_0004) begin n_fail++; $display("FAIL cc_complete: got %h expected 00000004", bus.complete); end
    step();
    bus.claim_re    = 1'b0;
    bus.complete_we = 1'b0;
    n_checks++; if (gw_ip[2] !== 1'b0 || gw_busy[2] !== 1'b0) begin n_fail++; $display("FAIL cc_gw_clear: got ip=%0b busy=%0b expected 0/0", gw_ip[2], gw_busy[2]); end
    n_checks++; if (irq_id !== 6'd0) begin n_fail++; $display("FAIL cc_blank: got %0d expected 0", irq_id); end
    step();
    n_checks++; if (gw_ip[2] !== 1'b1) begin n_fail++; $display("FAIL cc_rearm: got %0b expected 1", gw_ip[2]); end
    step();
    n_checks++; if (irq !== 1'b1 || irq_id !== 6'd3) begin n_fail++; $display("FAIL cc_reassert: got irq=%0b id=%0d expected 1/3", irq, irq_id); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_arbitration();
    test_claim();
    test_back_to_back();
    test_complete();
    test_claim_complete_same();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends even if a task stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/rv_plic_target.md
# rv_plic_target

Per-target priority arbiter for the PLIC, sitting directly downstream of `rv_plic_gateway`. It receives the gateway's pending vector, masks it with this target's enables, and selects the highest-priority source above the target threshold. It registers `irq` and `irq_id`, and turns register-interface claim and complete accesses into the one-hot `claim` and `complete` vectors the gateway consumes. Instantiate one per hart context.

## Interface
- `N_SOURCE`, default 32: number of interrupt sources. Source IDs are 1..N_SOURCE; ID 0 means "none".
- `MAX_PRIO`, default 7: highest priority level.
- `SRCW`, derived `$clog2(N_SOURCE+1)`: ID width.
- `PRIOW`, derived `$clog2(MAX_PRIO+1)`: priority width.

Ports:
- `clk_i` in 1: clock. This block uses one clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `ip` in N_SOURCE: pending bits from the gateway. Bit i is source ID i+1.
- `ie` in N_SOURCE: enables for this target.
- `prio` in N_SOURCE×PRIOW: per-source priority.
- `threshold` in PRIOW: target threshold.
- `claim_re` in 1: single-cycle strobe, a read of this target's claim register.
- `complete_we` in 1: single-cycle strobe, a write of this target's complete register.
- `complete_id` in SRCW: ID written with `complete_we`.
- `irq` out 1: registered interrupt request to the hart.
- `irq_id` out SRCW: registered winning ID. This is the value returned for a claim read.
- `claim` out N_SOURCE: one-hot or zero, to the gateway `claim` input.
- `complete` out N_SOURCE: one-hot or zero, to the gateway `complete` input.

## Operation
- Eligibility of source i: `ip[i] & ie[i] & (prio[i] > threshold)`. The compare is strict and unsigned, so priority 0 never interrupts and threshold MAX_PRIO masks everything.
- Winner: the eligible source with the highest `prio`. Ties go to the lowest ID. With no eligible source the winner is ID 0.
- Registered result:
  - On every edge, `irq_id` loads the winner ID and `irq` loads `(winner != 0)`.
  - Exception: the edge immediately after an accepted claim loads `irq=0` and `irq_id=0` (blanking).
- Claim:
  - When `claim_re` is high, `claim` is the one-hot of the current `irq_id` in the same cycle. Bit `irq_id-1` is high.
  - If `irq_id == 0`, `claim` is all zeros and the claim is not "accepted", so no blanking follows.
  - The read data for the claim is the current `irq_id`, valid in the same cycle.
- Complete:
  - When `complete_we` is high and 1 ≤ `complete_id` ≤ N_SOURCE, `complete` is the one-hot of `complete_id` in the same cycle.
  - ID 0 or an out-of-range ID produces all zeros and is silently ignored.
  - Completing an ID that was never claimed is passed through unchanged; the gateway tolerates it.
- `claim_re` and `complete_we` in the same cycle are both honoured independently, including when both refer to the same ID.
- `ie`, `prio` and `threshold` may change in any cycle. Their effect appears on `irq`/`irq_id` at the next edge, subject to blanking.

## Timing
- Reset: `irq=0` and `irq_id=0`. `claim` and `complete` are 0 because both strobes are low during reset.
- Latency from `ip`/`ie`/`prio`/`threshold` to `irq`/`irq_id` is 1 cycle.
- `claim` and `complete` are combinational from their strobes. They are valid in the strobe cycle only, and the gateway samples them on the next edge.
- Claim at cycle t:
  - `claim[k]` is high in cycle t.
  - Edge t+1: the gateway clears `ip[k]`, and this block blanks (`irq=0`, `irq_id=0`) during cycle t+1.
  - Edge t+2: the next winner, computed from the updated `ip`, is registered.
  - Consequence: a back-to-back claim at cycle t+1 reads 0 and never returns ID k twice.
- A claim asserted during a blank cycle reads 0 and is not accepted.
- If reset asserts mid-operation, all registers clear asynchronously, including any pending blank.

## Structure
- Shared package `rv_plic_pkg`, containing:
  - the ID-0 "no interrupt" constant;
  - the `src_id_t` and `prio_t` typedefs, parameterised through localparams, used by the gateway, target and register block.
- Sub-module `rv_plic_prio_tree`: a purely combinational log2(N_SOURCE)-depth max-tree returning winner ID and priority. At each node the left (lower-ID) input wins ties.
- The top level holds only:
  - the eligibility mask;
  - the result and blank registers;
  - the two one-hot decoders.

## Test plan
- Reset with `ip=all-1`, `ie=all-1`, all `prio=3` → `irq=0` and `irq_id=0` during reset. One edge after release, `irq=1` and `irq_id=1` (lowest-ID tie-break).
- `ip[4]=1`, `ip[9]=1`, `prio[4]=2`, `prio[9]=5`, `threshold=1` → `irq_id=10`. Raise threshold to 5 → `irq=0` one cycle later (strict compare).
- `irq_id=10` with `claim_re` pulsed → `claim=1<<9` in the same cycle, blank cycle next (`irq_id=0`). With the gateway model attached, `irq_id=5` the following cycle.
- `claim_re` held for 3 consecutive cycles with two sources pending → reads are ID, 0, then the second ID. No duplicate claim bit is ever asserted.
- `complete_we` with `complete_id` = 0, 7 and N_SOURCE+1 → `complete` = 0, `1<<6`, 0 respectively, with no effect on `irq`.
- `claim_re` and `complete_we` for the same ID 3 in one cycle → `claim` and `complete` both equal `1<<2`. The gateway model's `ip[2]` clears and it becomes re-armable.
